// File: rtl/slave_regfile.sv
// Slave-side write endpoint: valid/ready handshake into an 8 x 3-bit register file with a busy period after each accept.
// Optional accumulate mode with saturation flag is enabled by defining SLAVE_ACC_EN.
module slave_regfile #(
    parameter int BUSY_CYCLES = 2,
    parameter int DEPTH       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [2:0] addr,
    input  logic [2:0] value,
    output logic       ready,
    input  logic       clear,
    input  logic [2:0] rd_addr,
    output logic [2:0] rd_data,
    output logic [3:0] wr_count,
    output logic [7:0] wr_mask,
    output logic       all_written,
    output logic       sat_flag
);

    typedef enum logic {S_READY, S_BUSY} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(BUSY_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic [2:0]       regs [DEPTH];
    logic [DEPTH-1:0] mask_q;
    logic [3:0]       count_q;
    logic [2:0]       wr_value;

    assign accept = valid && ready_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_READY: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) state_d = S_READY;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_READY;
        endcase
        ready_d = (state_d == S_READY);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_READY;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

`ifdef SLAVE_ACC_EN
    logic [3:0] sum;
    logic       ovf;
    logic       sat_q;

    always_comb begin
        sum      = {1'b0, regs[addr]} + {1'b0, value};
        ovf      = (sum > 4'd7);
        wr_value = ovf ? 3'd7 : sum[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              sat_q <= 1'b0;
        else if (clear)          sat_q <= 1'b0;
        else if (accept && ovf)  sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    assign wr_value = value;
    assign sat_flag = 1'b0;
`endif

    // NOTE: the register file is small and must read 0 after reset, so it is reset explicitly rather than left to RAM inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 3'd0;
            mask_q  <= '0;
            count_q <= 4'd0;
        end else if (clear) begin
            // Clear wins over a coinciding accept; the handshake itself still completes in the FSM.
            for (int i = 0; i < DEPTH; i++) regs[i] <= 3'd0;
            mask_q  <= '0;
            count_q <= 4'd0;
        end else if (accept) begin
            regs[addr]   <= wr_value;
            mask_q[addr] <= 1'b1;
            if (count_q != 4'hF) count_q <= count_q + 4'd1;
        end
    end

    assign ready       = ready_q;
    assign rd_data     = regs[rd_addr];
    assign wr_count    = count_q;
    assign wr_mask     = mask_q;
    assign all_written = &mask_q;

endmodule
